// File: rtl/ex_result_stage.sv
// Elastic result buffer behind the execute-stage adder. Holds adder results in a
// small FIFO, converts signed add/sub overflow into a precise exception with a
// latched EPC, and updates the architectural zero/carry flags on retirement.
module ex_result_stage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctl,
    input  logic [DATA_W-1:0] add_result,
    input  logic              add_carry,
    input  logic              add_overflow,
    input  logic              add_zero,
    input  logic [DATA_W-1:0] pc,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_exc,
    output logic              flag_zero,
    output logic              flag_carry,
    input  logic              flush,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_epc,
    output logic [3:0]        exc_cause,
    input  logic              exc_ack
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] res_q [DEPTH];
    logic [4:0]        rd_q  [DEPTH];
    logic [DEPTH-1:0]  rw_q, exc_q, zero_q, carry_q;

    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              flag_zero_q, flag_zero_d, flag_carry_q, flag_carry_d;
    logic              exc_valid_q, exc_valid_d;
    logic [DATA_W-1:0] exc_epc_q, exc_epc_d;
    logic [3:0]        exc_cause_q, exc_cause_d;

    logic push, pop, trap, do_push, do_pop;

    // Handshake decode; in_ready looks at registers only.
    always_comb begin
        in_ready  = (count_q < CW'(DEPTH)) && !exc_valid_q;
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        trap      = add_overflow && (alu_ctl == 4'b0001 || alu_ctl == 4'b0011);
        // A flush discards any transfer in the same cycle.
        do_push   = push && !flush;
        do_pop    = pop && !flush;
    end

    // Head entry drives every output field.
    always_comb begin
        out_result    = res_q[rptr_q];
        out_rd        = rd_q[rptr_q];
        out_reg_write = rw_q[rptr_q];
        out_exc       = exc_q[rptr_q];
        flag_zero     = flag_zero_q;
        flag_carry    = flag_carry_q;
        exc_valid     = exc_valid_q;
        exc_epc       = exc_epc_q;
        exc_cause     = exc_cause_q;
    end

    // Next-state for pointers, count, flags and the exception latch.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        exc_valid_d  = exc_valid_q;
        exc_epc_d    = exc_epc_q;
        exc_cause_d  = exc_cause_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end

        // Overflow entries retire without touching the flags.
        if (do_pop && !exc_q[rptr_q]) begin
            flag_zero_d  = zero_q[rptr_q];
            flag_carry_d = carry_q[rptr_q];
        end

        // Set and ack cannot coincide: a push needs the latch to be clear.
        if (exc_valid_q && exc_ack) exc_valid_d = 1'b0;
        if (do_push && trap) begin
            exc_valid_d = 1'b1;
            exc_epc_d   = pc;
            exc_cause_d = alu_ctl;
        end
    end

    // Entry storage; reset so the idle outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
            end
            rw_q    <= '0;
            exc_q   <= '0;
            zero_q  <= '0;
            carry_q <= '0;
        end else if (do_push) begin
            res_q[wptr_q]   <= add_result;
            rd_q[wptr_q]    <= rd;
            rw_q[wptr_q]    <= reg_write && !trap;
            exc_q[wptr_q]   <= trap;
            zero_q[wptr_q]  <= add_zero;
            carry_q[wptr_q] <= add_carry;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_epc_q    <= '0;
            exc_cause_q  <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
            exc_valid_q  <= exc_valid_d;
            exc_epc_q    <= exc_epc_d;
            exc_cause_q  <= exc_cause_d;
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: a table of single-entry transactions plus
// hand-written fill/stall, flush and asynchronous reset sequences.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_ctl;
    logic [31:0] add_result;
    logic        add_carry, add_overflow, add_zero;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_exc;
    logic        flag_zero, flag_carry;
    logic        flush;
    logic        exc_valid;
    logic [31:0] exc_epc;
    logic [3:0]  exc_cause;
    logic        exc_ack;

    int checks   = 0;
    int failures = 0;

    ex_result_stage #(.DEPTH(2), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctl(alu_ctl), .add_result(add_result), .add_carry(add_carry),
        .add_overflow(add_overflow), .add_zero(add_zero),
        .pc(pc), .rd(rd), .reg_write(reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_exc(out_exc),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flush(flush),
        .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_cause(exc_cause),
        .exc_ack(exc_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        c, v, z;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        e_rw, e_exc, e_fz, e_fc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] r, input logic cy,
                         input logic ov, input logic z, input logic [31:0] p,
                         input logic [4:0] d, input logic w);
        alu_ctl = c; add_result = r; add_carry = cy; add_overflow = ov;
        add_zero = z; pc = p; rd = d; reg_write = w;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_rd"}, out_rd, 0);
        chk({tag, "_out_rw"}, out_reg_write, 0);
        chk({tag, "_out_exc"}, out_exc, 0);
        chk({tag, "_flag_zero"}, flag_zero, 0);
        chk({tag, "_flag_carry"}, flag_carry, 0);
        chk({tag, "_exc_valid"}, exc_valid, 0);
        chk({tag, "_exc_epc"}, exc_epc, 0);
        chk({tag, "_exc_cause"}, exc_cause, 0);
    endtask

    initial begin
        // ctl, res, carry, ovf, zero, pc, rd, rw, exp_rw, exp_exc, exp_fz, exp_fc
        vecs[0] = '{4'b0001, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 5'd3, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0010, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0104, 5'd7, 1'b1,
                    1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{4'b0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h0040_0020, 5'd4, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{4'b0011, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 5'd9, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0011, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 5'd2, 1'b1,
                    1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_010C, 5'd0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; exc_ack = 1'b0;
        drive(4'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: push one entry, inspect head, pop it, inspect flags and exception.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].ctl, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].pc,
                  vecs[i].rd, vecs[i].rw);
            chk($sformatf("v%0d_in_ready_pre", i), in_ready, 1);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_out_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_out_rw", i), out_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d_out_exc", i), out_exc, vecs[i].e_exc);
            chk($sformatf("v%0d_exc_valid", i), exc_valid, vecs[i].e_exc);
            chk($sformatf("v%0d_in_ready", i), in_ready, !vecs[i].e_exc);
            if (vecs[i].e_exc) begin
                chk($sformatf("v%0d_exc_epc", i), exc_epc, vecs[i].pc);
                chk($sformatf("v%0d_exc_cause", i), exc_cause, vecs[i].ctl);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d_empty", i), out_valid, 0);
            chk($sformatf("v%0d_flag_zero", i), flag_zero, vecs[i].e_fz);
            chk($sformatf("v%0d_flag_carry", i), flag_carry, vecs[i].e_fc);
            if (vecs[i].e_exc) begin
                chk($sformatf("v%0d_ready_held", i), in_ready, 0);
                exc_ack = 1'b1;
                step();
                exc_ack = 1'b0;
                chk($sformatf("v%0d_exc_cleared", i), exc_valid, 0);
                chk($sformatf("v%0d_ready_back", i), in_ready, 1);
            end
        end

        // Fill and stall: third push refused, full blocks even with out_ready.
        drive(4'b0001, 32'h11, 1'b0, 1'b0, 1'b0, 32'h200, 5'd1, 1'b1);
        in_valid = 1'b1;
        step();
        drive(4'b0001, 32'h22, 1'b0, 1'b0, 1'b0, 32'h204, 5'd2, 1'b1);
        step();
        chk("fill_full_ready", in_ready, 0);
        chk("fill_head", out_result, 32'h11);
        drive(4'b0001, 32'h33, 1'b0, 1'b0, 1'b0, 32'h208, 5'd3, 1'b1);
        out_ready = 1'b1;
        chk("fill_full_ready_outrdy", in_ready, 0);
        step();
        in_valid = 1'b0;
        chk("fill_second", out_result, 32'h22);
        chk("fill_second_rd", out_rd, 5'd2);
        chk("fill_ready_after_pop", in_ready, 1);
        step();
        out_ready = 1'b0;
        chk("fill_drained", out_valid, 0);

        // Flush on a full buffer with pending exception: flags and latch survive.
        drive(4'b0010, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300, 5'd5, 1'b1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("flush_pre_fz", flag_zero, 1);
        chk("flush_pre_fc", flag_carry, 1);
        drive(4'b0001, 32'h55, 1'b0, 1'b0, 1'b0, 32'h304, 5'd6, 1'b1);
        in_valid = 1'b1;
        step();
        drive(4'b0001, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 32'h308, 5'd8, 1'b1);
        step();
        chk("flush_pre_full", out_valid, 1);
        chk("flush_pre_exc", exc_valid, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_exc_kept", exc_valid, 1);
        chk("flush_epc_kept", exc_epc, 32'h308);
        chk("flush_fz_kept", flag_zero, 1);
        chk("flush_fc_kept", flag_carry, 1);
        chk("flush_ready_blocked", in_ready, 0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        chk("flush_ack_ready", in_ready, 1);
        chk("flush_still_empty", out_valid, 0);

        // Asynchronous reset with two entries and an exception pending.
        drive(4'b0001, 32'h66, 1'b1, 1'b0, 1'b0, 32'h400, 5'd10, 1'b1);
        in_valid = 1'b1;
        step();
        drive(4'b0011, 32'h7FFF_0000, 1'b0, 1'b1, 1'b0, 32'h404, 5'd11, 1'b1);
        step();
        in_valid = 1'b0;
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_exc", exc_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_post_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
